// File: rtl/ram_sp_pkg.sv
// Shared widths and word/address types for the single-port scratch RAM.
package ram_sp_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 8;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] data_t;
    typedef logic [DEFAULT_ADDR_WIDTH-1:0] addr_t;

endpackage

// File: rtl/ram_sp_array.sv
// Storage array: synchronous write, registered read, synchronous clear of every word.
module ram_sp_array
    import ram_sp_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DEPTH      = 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr,
    input  logic                  rd,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rd_q
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Clear must reach every word, so reset stays in the same process as the array.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_q <= '0;
        end else begin
            if (wr) begin
                mem[addr] <= wdata;
            end
            if (rd) begin
                rd_q <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/ram_single_port.sv
// Single-port RAM top: enable decode and the tri-state driver for the shared data bus.
module ram_single_port
    import ram_sp_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DEPTH      = 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  read_en,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    inout  wire  [DATA_WIDTH-1:0] data
);

    logic                  wr;
    logic                  rd;
    logic [DATA_WIDTH-1:0] rd_q;

    // Both enables high is treated as idle so the RAM never fights the host.
    assign wr = write_en && !read_en;
    assign rd = read_en && !write_en;

    ram_sp_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (wr),
        .rd    (rd),
        .addr  (addr),
        .wdata (data),
        .rd_q  (rd_q)
    );

    assign data = rd ? rd_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_ram_single_port.sv
// Directed bench for ram_single_port: array model plus literal expectations on the shared bus.
module tb_ram_single_port;
    import ram_sp_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       read_en = 1'b0;
    logic       write_en = 1'b0;
    addr_t      addr = '0;
    logic       host_drive = 1'b0;
    data_t      host_val = '0;
    wire  [7:0] data_bus;

    int checks = 0;
    int errors = 0;
    bit armed = 1'b0;

    data_t mem_model [256];
    data_t rd_model;

    assign data_bus = host_drive ? host_val : 8'hzz;

    ram_single_port dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .read_en  (read_en),
        .write_en (write_en),
        .addr     (addr),
        .data     (data_bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory as the host sees it: reset wipes it, a lone write stores, a lone read latches.
    always @(posedge clk) begin
        if (!rst_n) begin
            foreach (mem_model[i]) mem_model[i] = 8'h00;
            rd_model = 8'h00;
        end else if (write_en && !read_en) begin
            mem_model[addr] = host_val;
        end else if (read_en && !write_en) begin
            rd_model = mem_model[addr];
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            if (read_en && !write_en)
                check("bus_read", data_bus, rd_model);
            else if (host_drive)
                check("bus_host", data_bus, host_val);
        end
    end

    task automatic step(input logic rn, input logic re, input logic we, input addr_t a,
                        input logic hd, input data_t hv);
        #2;
        rst_n      = rn;
        read_en    = re;
        write_en   = we;
        addr       = a;
        host_drive = hd;
        host_val   = hv;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rd_lit(input string name, input addr_t a, input data_t exp);
        step(1'b1, 1'b1, 1'b0, a, 1'b0, 8'h00);
        check(name, data_bus, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        armed = 1'b1;

        for (int i = 0; i < 16; i++) rd_lit("reset_zero", addr_t'(i), 8'h00);

        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b1, addr_t'(i), 1'b1, data_t'(i));
        for (int i = 0; i < 16; i++) rd_lit("seq_read", addr_t'(i), data_t'(i));

        step(1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 8'hA5);
        step(1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 8'h5A);
        rd_lit("top_addr", 8'hFF, 8'hA5);
        rd_lit("addr_zero", 8'h00, 8'h5A);
        rd_lit("untouched", 8'h80, 8'h00);

        // Both enables: RAM must neither drive nor store the host's 0x77.
        step(1'b1, 1'b1, 1'b1, 8'h03, 1'b1, 8'h77);
        check("both_high_bus", data_bus, 8'h77);
        rd_lit("after_both", 8'h03, 8'h03);

        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'hC3);
        check("idle_release", data_bus, 8'hC3);

        #2;
        host_drive = 1'b0;
        read_en    = 1'b1;
        addr       = 8'h0A;
        #1;
        check("rise_immediate", data_bus, 8'h03);
        @(posedge clk);
        @(negedge clk);
        check("rise_updated", data_bus, 8'h0A);

        rd_lit("pre_reset", 8'h05, 8'h05);
        step(1'b0, 1'b1, 1'b0, 8'h06, 1'b0, 8'h00);
        check("reset_bus", data_bus, 8'h00);
        for (int i = 0; i < 16; i++) rd_lit("post_reset", addr_t'(i), 8'h00);
        rd_lit("post_reset_top", 8'hFF, 8'h00);

        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
